// File: rtl/alu_muldiv_seq_if.sv
// Bundle between the core and the MULTU/DIVU sequencer: request, shared ALU
// lines and result registers.
// Ports: start/op/rs_val/rt_val request, alu_a/alu_b/alu_sel/alu_own out to the ALU mux,
//        alu_o/alu_co back from the ALU, busy/done/dz/hi/lo status and results.
interface alu_muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_o;
  logic        alu_co;
  logic        alu_own;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  // Core side: issues requests and supplies the ALU result.
  modport master (
    output start, op, rs_val, rt_val, alu_o, alu_co,
    input  alu_a, alu_b, alu_sel, alu_own, busy, done, dz, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  start, op, rs_val, rt_val, alu_o, alu_co,
    output alu_a, alu_b, alu_sel, alu_own, busy, done, dz, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Purpose: unsigned MULTU/DIVU by sequencing the shared 32-bit ALU through 32 add/subtract steps.
// Latency: done pulses 33 cycles after the start cycle (1 cycle for divide-by-zero).
// Backpressure: none; start is only sampled in IDLE and is silently dropped while busy.
// Ports: i_clk, i_reset (sync, active-high); bus (slave modport) carries the request,
//        the ALU operand/select lines, the ALU result and the busy/done/dz/hi/lo outputs.
module alu_muldiv_seq #(
  parameter logic [2:0] SEL_ADD = 3'b010,
  parameter logic [2:0] SEL_SUB = 3'b110,
  parameter int         ITER    = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  alu_muldiv_seq_if.slave    bus
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_op;     // 0 = MULTU, 1 = DIVU
  logic [31:0]    r_md;     // multiplier or divisor
  logic [31:0]    r_hi;
  logic [31:0]    r_lo;
  logic           r_own;
  logic           r_busy;
  logic           r_done;
  logic           r_dz;

  // Divide step: remainder shifted left with the next dividend bit. The bit
  // shifted out of hi is the 33rd remainder bit; when set the remainder
  // certainly exceeds the divisor even if the ALU subtraction borrows.
  logic [31:0] w_div_r;
  logic        w_div_msb;
  logic        w_div_acc;

  assign w_div_r   = {r_hi[30:0], r_lo[31]};
  assign w_div_msb = r_hi[31];
  assign w_div_acc = w_div_msb | bus.alu_co;

  // ALU lines are parked at 0 + 0 whenever the core owns the ALU.
  assign bus.alu_a   = !r_own ? 32'd0 : (r_op ? w_div_r : r_hi);
  assign bus.alu_b   = !r_own ? 32'd0 : r_md;
  assign bus.alu_sel = (r_own && r_op) ? SEL_SUB : SEL_ADD;

  assign bus.alu_own = r_own;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dz      = r_dz;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= 1'b0;
      r_md    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_own   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_md    <= bus.rt_val;
            r_count <= '0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b1;
            if (bus.op && (bus.rt_val == 32'd0)) begin
              // Divide by zero: canned result, skip the iterations.
              r_hi    <= bus.rs_val;
              r_lo    <= '1;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Both operations start with hi cleared and rs in lo
              // (multiplicand for MULTU, dividend for DIVU).
              r_hi    <= '0;
              r_lo    <= bus.rs_val;
              r_own   <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_count <= r_count + 1'b1;
          if (!r_op) begin
            // Shift-add multiply; the add's carry becomes the new hi msb.
            if (r_lo[0]) begin
              r_hi <= {bus.alu_co, bus.alu_o[31:1]};
              r_lo <= {bus.alu_o[0], r_lo[31:1]};
            end else begin
              r_hi <= {1'b0, r_hi[31:1]};
              r_lo <= {r_hi[0], r_lo[31:1]};
            end
          end else begin
            if (w_div_acc) begin
              r_hi <= bus.alu_o;
              r_lo <= {r_lo[30:0], 1'b1};
            end else begin
              r_hi <= w_div_r;
              r_lo <= {r_lo[30:0], 1'b0};
            end
          end
          if (r_count == LAST) begin
            r_own   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  // Behavioural shared ALU: A + B, or A + ~B + 1 when select bit 2 is set.
  logic [32:0] alu_sum;
  assign alu_sum    = {1'b0, bus.alu_a}
                    + {1'b0, (bus.alu_sel[2] ? ~bus.alu_b : bus.alu_b)}
                    + {32'd0, bus.alu_sel[2]};
  assign bus.alu_o  = alu_sum[31:0];
  assign bus.alu_co = alu_sum[32];

  // Reference: plain 64-bit product, integer quotient/remainder.
  task automatic ref_model(input logic op, input logic [31:0] rs, input logic [31:0] rt,
                           output logic [31:0] e_hi, output logic [31:0] e_lo,
                           output logic e_dz, output int e_lat);
    logic [63:0] p;
    if (!op) begin
      p = {32'd0, rs} * {32'd0, rt};
      e_hi = p[63:32]; e_lo = p[31:0]; e_dz = 1'b0; e_lat = 33;
    end else if (rt == 32'd0) begin
      e_hi = rs; e_lo = 32'hFFFFFFFF; e_dz = 1'b1; e_lat = 1;
    end else begin
      e_hi = rs % rt; e_lo = rs / rt; e_dz = 1'b0; e_lat = 33;
    end
  endtask

  // Issues one request and observes it; inputs are scrambled after acceptance.
  // inject_at > 0 raises start again with junk operands at that cycle.
  task automatic run_op(input logic op, input logic [31:0] rs, input logic [31:0] rt,
                        input int inject_at,
                        output int done_at, output int own_cnt, output int done_cnt,
                        output int bad_idle, output logic busy_at_done, output logic busy_after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
    done_at = -1; own_cnt = 0; done_cnt = 0; bad_idle = 0;
    busy_at_done = 1'b0; busy_after = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1 || n == inject_at + 1) begin
        bus.start = 1'b0; bus.op = 1'($urandom);
        bus.rs_val = $urandom; bus.rt_val = $urandom;
      end
      if (n == inject_at) begin
        bus.start = 1'b1; bus.op = 1'($urandom);
        bus.rs_val = $urandom; bus.rt_val = $urandom;
      end
      if (bus.alu_own) own_cnt++;
      else if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_sel !== 3'b010) bad_idle++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = n; busy_at_done = bus.busy; end
      end
      if (done_at > 0 && n == done_at + 1) busy_after = bus.busy;
      if (done_at > 0 && n >= done_at + 3) break;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 1'b0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.alu_own !== 1'b0 || bus.dz !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b own=%b dz=%b want all 0", bus.busy, bus.done, bus.alu_own, bus.dz);
    else pass_cnt++;
    chk_cnt++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL reset_hilo hi=%h lo=%h want 0/0", bus.hi, bus.lo);
    else pass_cnt++;
    chk_cnt++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_sel !== 3'b010)
      $display("FAIL reset_alu a=%h b=%h sel=%b want 0/0/010", bus.alu_a, bus.alu_b, bus.alu_sel);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    int da, oc, dc, bi; logic bd, ba;
    run_op(1'b0, 32'd7, 32'd6, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (da !== 33) $display("FAIL mul7x6_latency got %0d want 33", da); else pass_cnt++;
    chk_cnt++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42 || bus.dz !== 1'b0)
      $display("FAIL mul7x6_result hi=%h lo=%h dz=%b want 0/2a/0", bus.hi, bus.lo, bus.dz);
    else pass_cnt++;
    chk_cnt++; if (oc !== 32) $display("FAIL mul7x6_own_cycles got %0d want 32", oc); else pass_cnt++;
    chk_cnt++; if (dc !== 1) $display("FAIL mul7x6_done_width got %0d want 1", dc); else pass_cnt++;
    chk_cnt++; if (bd !== 1'b1 || ba !== 1'b0)
      $display("FAIL mul7x6_busy at_done=%b after=%b want 1/0", bd, ba);
    else pass_cnt++;
    chk_cnt++; if (bi !== 0) $display("FAIL mul7x6_idle_alu got %0d bad cycles want 0", bi); else pass_cnt++;
  endtask

  task automatic test_mul_max();
    int da, oc, dc, bi; logic bd, ba;
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001)
      $display("FAIL mul_max hi=%h lo=%h want fffffffe/00000001", bus.hi, bus.lo);
    else pass_cnt++;
  endtask

  task automatic test_div_basic();
    int da, oc, dc, bi; logic bd, ba;
    run_op(1'b1, 32'd100, 32'd7, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || da !== 33)
      $display("FAIL div100_7 lo=%0d hi=%0d lat=%0d want 14/2/33", bus.lo, bus.hi, da);
    else pass_cnt++;
    run_op(1'b1, 32'hFFFFFFFF, 32'h80000001, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (bus.lo !== 32'd1 || bus.hi !== 32'h7FFFFFFE)
      $display("FAIL div_msb lo=%h hi=%h want 00000001/7ffffffe", bus.lo, bus.hi);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int da, oc, dc, bi; logic bd, ba;
    run_op(1'b1, 32'h1234, 32'd0, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (da !== 1) $display("FAIL divz_latency got %0d want 1", da); else pass_cnt++;
    chk_cnt++; if (bus.dz !== 1'b1 || bus.hi !== 32'h1234 || bus.lo !== 32'hFFFFFFFF)
      $display("FAIL divz_result dz=%b hi=%h lo=%h want 1/00001234/ffffffff", bus.dz, bus.hi, bus.lo);
    else pass_cnt++;
    chk_cnt++; if (oc !== 0 || dc !== 1)
      $display("FAIL divz_own own=%0d done=%0d want 0/1", oc, dc);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int da, oc, dc, bi; logic bd, ba;
    run_op(1'b0, 32'd1000, 32'd3000, 10, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (da !== 33 || dc !== 1 || bus.hi !== 32'd0 || bus.lo !== 32'd3000000)
      $display("FAIL busy_start lat=%0d dones=%0d hi=%h lo=%h want 33/1/0/002dc6c0", da, dc, bus.hi, bus.lo);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int da, oc, dc, bi; int seen; logic bd, ba;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.rs_val = 32'h12345; bus.rt_val = 32'h777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_cnt++; if (bus.busy !== 1'b0 || bus.alu_own !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
      $display("FAIL midreset_state busy=%b own=%b done=%b hi=%h lo=%h want 0/0/0/0/0",
               bus.busy, bus.alu_own, bus.done, bus.hi, bus.lo);
    else pass_cnt++;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL midreset_quiet got %0d active cycles want 0", seen); else pass_cnt++;
    run_op(1'b1, 32'd9, 32'd3, 0, da, oc, dc, bi, bd, ba);
    chk_cnt++; if (bus.lo !== 32'd3 || bus.hi !== 32'd0 || da !== 33)
      $display("FAIL midreset_div lo=%0d hi=%0d lat=%0d want 3/0/33", bus.lo, bus.hi, da);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int da, oc, dc, bi; logic bd, ba;
    logic op; logic [31:0] rs, rt, e_hi, e_lo; logic e_dz; int e_lat;
    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom);
      rs = $urandom;
      case ($urandom_range(0, 3))
        0:       rt = 32'd0;
        1:       rt = $urandom_range(1, 255);
        default: rt = $urandom;
      endcase
      ref_model(op, rs, rt, e_hi, e_lo, e_dz, e_lat);
      run_op(op, rs, rt, 0, da, oc, dc, bi, bd, ba);
      chk_cnt++; if (bus.hi !== e_hi || bus.lo !== e_lo || bus.dz !== e_dz || da !== e_lat || dc !== 1 || bi !== 0)
        $display("FAIL rand%0d op=%b rs=%h rt=%h got hi=%h lo=%h dz=%b lat=%0d dones=%0d idlebad=%0d want hi=%h lo=%h dz=%b lat=%0d dones=1 idlebad=0",
                 i, op, rs, rt, bus.hi, bus.lo, bus.dz, da, dc, bi, e_hi, e_lo, e_dz, e_lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div_basic();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that reuses the shared 32-bit ALU to execute unsigned MULTU and DIVU for the MIPS32 core.
- Accepts a start pulse with operands and sequences the ALU through 32 add or subtract iterations.
- Writes the results into internal HI/LO registers and reports completion with a one-cycle done pulse.
- While busy it owns the ALU operand and select lines; the core's operand mux gives the ALU to the block whenever alu_own=1.

Parameters:
- SEL_ADD, 3'b010, ALU select code for A+B (carry-in 0).
- SEL_SUB, 3'b110, ALU select code for A-B (bit 2 is the carry-in, so the ALU computes A+~B+1).
- ITER, 32, number of iterations; fixed by the 32-bit datapath.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  1  0=MULTU, 1=DIVU; captured when start is accepted.
- rs_val  in  32  multiplicand / dividend.
- rt_val  in  32  multiplier / divisor.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_sel  out  3  ALU select S.
- alu_o  in  32  ALU result O.
- alu_co  in  1  ALU carry out Co.
- alu_own  out  1  1 while the block drives the ALU (CALC state).
- busy  out  1  1 in CALC and DONE.
- done  out  1  one-cycle completion pulse.
- dz  out  1  divide-by-zero flag; valid with done, held until next accepted start.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (synchronous, takes priority in any state, including mid-operation):
  - state=IDLE, count=0, hi=0, lo=0, done=0, dz=0, alu_own=0.
  - Captured operands are discarded.
- Outputs when alu_own=0: alu_a=0, alu_b=0, alu_sel=SEL_ADD.
- IDLE:
  - On start=1: latch op and rt_val into an operand register (M/D), count=0, dz=0.
  - MULTU: hi=0, lo=rs_val.
  - DIVU with rt_val=0: hi=rs_val, lo=32'hFFFFFFFF, dz=1, go to DONE directly.
  - Otherwise go to CALC.
  - start=0: stay in IDLE.
- CALC, MULTU iteration (alu_sel=SEL_ADD, alu_a=hi, alu_b=M):
  - If lo[0]=1: {c,hi,lo} = {alu_co, alu_o, lo} >> 1.
  - Else: {hi,lo} = {1'b0, hi, lo} >> 1.
- CALC, DIVU iteration (restoring; remainder in hi, quotient in lo):
  - Shifted value: {msb, r} = {hi, lo[31]}, with msb = old hi[31].
  - Drive alu_sel=SEL_SUB, alu_a=r, alu_b=D.
  - Accept when (msb | alu_co)=1: hi=alu_o, lo={lo[30:0],1'b1}.
  - Otherwise: hi=r, lo={lo[30:0],1'b0}.
- CALC sequencing:
  - count increments every cycle.
  - On the iteration where count==ITER-1, go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then return to IDLE.
- Latency:
  - Start accepted at edge k; CALC occupies edges k+1..k+32; done=1 in the cycle after edge k+32.
  - Divide-by-zero: done=1 in the cycle after edge k.
- hi/lo are stable from done until the next accepted start.
- start while busy=1 is ignored; no queuing and no error.
- op, rs_val and rt_val may change freely after acceptance without affecting the result.
- The ALU Zero and Ow outputs are not used.

Test Plan:
- MULTU rs=7, rt=6 -> done exactly 33 cycles after start; hi=0, lo=42, dz=0; alu_own=1 for exactly 32 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (checks carry capture into the shift).
- DIVU 100/7 -> lo=14, hi=2. DIVU 0xFFFFFFFF/0x80000001 -> lo=1, hi=0x7FFFFFFE (checks the msb accept path).
- DIVU 0x1234/0 -> done 1 cycle after start; dz=1, hi=0x1234, lo=0xFFFFFFFF; alu_own never asserted.
- Start a MULTU, assert start with new operands at cycle 10 -> ignored; original result returned at cycle 33.
- Assert reset at CALC cycle 15 -> next cycle IDLE with hi=lo=0, busy=0, alu_own=0, no done; a new DIVU 9/3 afterwards gives lo=3, hi=0.
